// File: rtl/bist_signature_checker.sv
// Compacts the CUT response in a MISR while running is high, then checks it against golden values on bist_end.
// done/pass/fail appear two edges after bist_end is seen in CAPTURE. There is no backpressure: the block samples every cycle.
module bist_signature_checker #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = 8'h1D,
  parameter logic [WIDTH-1:0] SEED       = 8'h00,
  parameter logic [WIDTH-1:0] GOLDEN     = 8'h00,
  parameter int               CNT_W      = 14,
  parameter int               EXP_CYCLES = 9746
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             running,
  input  logic             bist_end,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] cycles,
  output logic             done,
  output logic             pass,
  output logic             fail
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  logic   result_ok;

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                 input logic [WIDTH-1:0] d);
    misr_step = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ d;
  endfunction

  assign result_ok = (signature == GOLDEN) && (cycles == EXP_CNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      signature <= SEED;
      cycles    <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
    end else begin
      case (state)
        // A new run restarts from SEED, so DONE behaves exactly like IDLE.
        IDLE, DONE: begin
          if (running) begin
            signature <= misr_step(SEED, data_in);
            cycles    <= CNT_W'(1);
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (running) begin
            signature <= misr_step(signature, data_in);
            if (cycles != CNT_MAX) cycles <= cycles + CNT_W'(1);
          end else if (bist_end) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          done  <= 1'b1;
          pass  <= result_ok;
          fail  <= !result_ok;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_signature_checker.sv
// Directed bench: three small 4-bit checkers with differing golden values plus one default-parameter checker.
`timescale 1ns/1ps
module tb_bist_signature_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       running, bist_end;
  logic [3:0] data_in;
  logic       running_d, bist_end_d;
  logic [7:0] data_d;

  logic [3:0]  sig_a, sig_b, sig_c;
  logic [3:0]  cyc_a, cyc_b, cyc_c;
  logic        done_a, pass_a, fail_a;
  logic        done_b, pass_b, fail_b;
  logic        done_c, pass_c, fail_c;
  logic [7:0]  sig_d;
  logic [13:0] cyc_d;
  logic        done_d, pass_d, fail_d;

  int n_cmp = 0;
  int n_err = 0;

  always #50 clk = ~clk;

  bist_signature_checker #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'hC),
                           .CNT_W(4), .EXP_CYCLES(5)) dut_a (
    .clk(clk), .reset(reset), .running(running), .bist_end(bist_end), .data_in(data_in),
    .signature(sig_a), .cycles(cyc_a), .done(done_a), .pass(pass_a), .fail(fail_a));

  bist_signature_checker #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'hD),
                           .CNT_W(4), .EXP_CYCLES(5)) dut_b (
    .clk(clk), .reset(reset), .running(running), .bist_end(bist_end), .data_in(data_in),
    .signature(sig_b), .cycles(cyc_b), .done(done_b), .pass(pass_b), .fail(fail_b));

  bist_signature_checker #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .GOLDEN(4'hC),
                           .CNT_W(4), .EXP_CYCLES(6)) dut_c (
    .clk(clk), .reset(reset), .running(running), .bist_end(bist_end), .data_in(data_in),
    .signature(sig_c), .cycles(cyc_c), .done(done_c), .pass(pass_c), .fail(fail_c));

  bist_signature_checker dut_d (
    .clk(clk), .reset(reset), .running(running_d), .bist_end(bist_end_d), .data_in(data_d),
    .signature(sig_d), .cycles(cyc_d), .done(done_d), .pass(pass_d), .fail(fail_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; running = 1'b0; bist_end = 1'b0; data_in = 4'h0;
    running_d = 1'b0; bist_end_d = 1'b0; data_d = 8'h00;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if ({sig_a, cyc_a} !== 8'h00) begin n_err++;
      $display("FAIL reset_sig_cyc got %h want 00", {sig_a, cyc_a}); end
    n_cmp++; if ({done_a, pass_a, fail_a} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags got %b want 000", {done_a, pass_a, fail_a}); end
    n_cmp++; if ({sig_d, cyc_d, done_d, pass_d, fail_d} !== 25'h0) begin n_err++;
      $display("FAIL reset_default got %h want 0", {sig_d, cyc_d, done_d, pass_d, fail_d}); end
    tick();
    n_cmp++; if ({sig_a, cyc_a, done_a} !== 9'h0) begin n_err++;
      $display("FAIL idle_hold got %h want 0", {sig_a, cyc_a, done_a}); end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] exp_sig [3];
    exp_sig[0] = 4'h1; exp_sig[1] = 4'h3; exp_sig[2] = 4'h7;
    running = 1'b1; data_in = 4'h1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (sig_a !== exp_sig[i] || cyc_a !== 4'(i + 1)) begin n_err++;
        $display("FAIL midrun_step%0d got sig=%h cyc=%0d want sig=%h cyc=%0d",
                 i, sig_a, cyc_a, exp_sig[i], i + 1); end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; running = 1'b0;
    n_cmp++; if ({sig_a, cyc_a, done_a} !== 9'h0) begin n_err++;
      $display("FAIL midrun_reset got %h want 0", {sig_a, cyc_a, done_a}); end
    bist_end = 1'b1;
    tick();
    bist_end = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if ({sig_a, cyc_a, done_a, pass_a, fail_a} !== 11'h0) begin n_err++;
      $display("FAIL idle_bist_end got %h want 0", {sig_a, cyc_a, done_a, pass_a, fail_a}); end
  endtask

  // Includes a gap cycle and two cycles with running and bist_end both high.
  task automatic test_pass_fail();
    logic [3:0] exp_sig [6];
    logic [3:0] exp_cyc [6];
    logic       run_v [6];
    logic       end_v [6];
    exp_sig[0] = 4'h1; exp_cyc[0] = 4'd1; run_v[0] = 1'b1; end_v[0] = 1'b0;
    exp_sig[1] = 4'h3; exp_cyc[1] = 4'd2; run_v[1] = 1'b1; end_v[1] = 1'b0;
    exp_sig[2] = 4'h3; exp_cyc[2] = 4'd2; run_v[2] = 1'b0; end_v[2] = 1'b0;
    exp_sig[3] = 4'h7; exp_cyc[3] = 4'd3; run_v[3] = 1'b1; end_v[3] = 1'b1;
    exp_sig[4] = 4'hF; exp_cyc[4] = 4'd4; run_v[4] = 1'b1; end_v[4] = 1'b1;
    exp_sig[5] = 4'hC; exp_cyc[5] = 4'd5; run_v[5] = 1'b1; end_v[5] = 1'b0;
    data_in = 4'h1;
    for (int i = 0; i < 6; i++) begin
      running = run_v[i]; bist_end = end_v[i];
      tick();
      n_cmp++; if (sig_a !== exp_sig[i] || cyc_a !== exp_cyc[i] || done_a !== 1'b0) begin n_err++;
        $display("FAIL run_step%0d got sig=%h cyc=%0d done=%b want sig=%h cyc=%0d done=0",
                 i, sig_a, cyc_a, done_a, exp_sig[i], exp_cyc[i]); end
    end
    running = 1'b0; bist_end = 1'b1;
    tick();
    bist_end = 1'b0;
    n_cmp++; if ({done_a, sig_a, cyc_a} !== {1'b0, 4'hC, 4'd5}) begin n_err++;
      $display("FAIL check_latency got done=%b sig=%h cyc=%0d want done=0 sig=c cyc=5",
               done_a, sig_a, cyc_a); end
    tick();
    n_cmp++; if ({done_a, pass_a, fail_a} !== 3'b110) begin n_err++;
      $display("FAIL pass_a got %b want 110", {done_a, pass_a, fail_a}); end
    n_cmp++; if ({done_b, pass_b, fail_b} !== 3'b101) begin n_err++;
      $display("FAIL golden_mismatch got %b want 101", {done_b, pass_b, fail_b}); end
    n_cmp++; if ({done_c, pass_c, fail_c} !== 3'b101) begin n_err++;
      $display("FAIL count_mismatch got %b want 101", {done_c, pass_c, fail_c}); end
    tick(); tick();
    n_cmp++; if ({done_a, pass_a, fail_a, sig_a} !== {3'b110, 4'hC}) begin n_err++;
      $display("FAIL done_hold got %b want 1101100", {done_a, pass_a, fail_a, sig_a}); end
  endtask

  task automatic test_restart();
    logic [3:0] din [5];
    logic [3:0] exp_sig [5];
    din[0] = 4'h2; exp_sig[0] = 4'h2;
    din[1] = 4'h1; exp_sig[1] = 4'h5;
    din[2] = 4'h1; exp_sig[2] = 4'hB;
    din[3] = 4'h1; exp_sig[3] = 4'h4;
    din[4] = 4'h4; exp_sig[4] = 4'hC;
    running = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = din[i];
      tick();
      n_cmp++; if (sig_a !== exp_sig[i] || cyc_a !== 4'(i + 1) || {done_a, pass_a} !== 2'b00) begin
        n_err++;
        $display("FAIL restart_step%0d got sig=%h cyc=%0d dp=%b want sig=%h cyc=%0d dp=00",
                 i, sig_a, cyc_a, {done_a, pass_a}, exp_sig[i], i + 1); end
    end
    running = 1'b0; bist_end = 1'b1;
    tick();
    bist_end = 1'b0;
    tick();
    n_cmp++; if ({done_a, pass_a, fail_a} !== 3'b110) begin n_err++;
      $display("FAIL restart_result got %b want 110", {done_a, pass_a, fail_a}); end
  endtask

  task automatic test_saturate();
    running = 1'b1; data_in = 4'h1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_cmp++; if (cyc_a !== 4'((i < 15) ? i : 15)) begin n_err++;
        $display("FAIL sat_edge%0d got cyc=%0d want %0d", i, cyc_a, (i < 15) ? i : 15); end
    end
    running = 1'b0; bist_end = 1'b1;
    tick();
    bist_end = 1'b0;
    tick();
    n_cmp++; if ({done_a, pass_a, fail_a, cyc_a} !== {3'b101, 4'd15}) begin n_err++;
      $display("FAIL sat_result got %b want 1011111", {done_a, pass_a, fail_a, cyc_a}); end
  endtask

  // Mimics the controller: 18 bursts of 513 running cycles and one of 512, one-cycle gaps between.
  task automatic test_controller_run();
    data_d = 8'h00;
    for (int s = 0; s < 19; s++) begin
      running_d = 1'b1;
      repeat ((s < 18) ? 513 : 512) tick();
      running_d = 1'b0;
      if (s < 18) tick();
    end
    n_cmp++; if (cyc_d !== 14'd9746 || done_d !== 1'b0) begin n_err++;
      $display("FAIL ctrl_count got cyc=%0d done=%b want cyc=9746 done=0", cyc_d, done_d); end
    bist_end_d = 1'b1;
    tick();
    bist_end_d = 1'b0;
    n_cmp++; if (done_d !== 1'b0) begin n_err++;
      $display("FAIL ctrl_latency got done=%b want 0", done_d); end
    tick();
    n_cmp++; if ({done_d, pass_d, fail_d, sig_d} !== {3'b110, 8'h00}) begin n_err++;
      $display("FAIL ctrl_result got %b want 11000000000", {done_d, pass_d, fail_d, sig_d}); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_pass_fail();
    test_restart();
    test_saturate();
    test_controller_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
